a3000_spi_flash_bridge: RTL

//  Parametrised SPI-slave to parallel-flash bridge for the A3000 ROM emulator CPLD.
//  The MCU frames each flash read or write over SPI; the bridge arbitrates flash ownership

---
 rtl/a3000_spi_flash_bridge_pkg.sv | 41 ++++
 rtl/a3000_spi_flash_bridge_if.sv | 28 ++
 rtl/a3000_spi_flash_bridge_spi_slave_sync.sv | 48 ++++
 rtl/a3000_spi_flash_bridge.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/a3000_spi_flash_bridge_pkg.sv
// rtl/a3000_spi_flash_bridge_pkg.sv - shared types and frame geometry for the A3000 SPI flash bridge
//
// Purpose: flash FSM state encoding and helpers that derive the SPI frame layout
//          (header length, payload length, counter width) from the bridge widths.
// Ports:   none (package).

package a3000_bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_STROBE = 2'd2,
        ST_HOLD   = 2'd3
    } flash_state_t;

    // Leading acc and rnw flag bits ahead of the address field.
    localparam int HDR_FLAG_BITS = 2;

    localparam int DEF_ADDR_W     = 22;
    localparam int DEF_DATA_W     = 32;
    localparam int DEF_GAP_BITS   = 8;
    localparam int DEF_STROBE_CYC = 4;

    function automatic int hdr_len(input int addr_w);
        return HDR_FLAG_BITS + addr_w;
    endfunction

    function automatic int payload_len(input int data_w, input int gap_bits);
        return data_w + gap_bits;
    endfunction

    function automatic int frame_len(input int addr_w, input int data_w, input int gap_bits);
        return hdr_len(addr_w) + payload_len(data_w, gap_bits);
    endfunction

    // Bit position counter must hold 0..frame_len-1.
    function automatic int cnt_width(input int flen);
        return $clog2(flen + 1);
    endfunction

endpackage

// File: rtl/a3000_spi_flash_bridge_if.sv
// rtl/a3000_spi_flash_bridge_if.sv - parallel flash bus between bridge and flash array
//
// Purpose: groups the flash address/data/strobe signals.
// Ports:   master = bridge (drives A, D_out, D_oe, nCE/nOE/nWE; reads D_in)
//          slave  = flash side (the reverse).

interface a3000_spi_flash_bridge_if #(
    parameter int ADDR_W = 22,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] flash_A;
    logic [DATA_W-1:0] flash_D_in;
    logic [DATA_W-1:0] flash_D_out;
    logic              flash_D_oe;
    logic              flash_nCE;
    logic              flash_nOE;
    logic              flash_nWE;

    modport master (
        output flash_A, flash_D_out, flash_D_oe, flash_nCE, flash_nOE, flash_nWE,
        input  flash_D_in
    );

    modport slave (
        input  flash_A, flash_D_out, flash_D_oe, flash_nCE, flash_nOE, flash_nWE,
        output flash_D_in
    );
endinterface

// File: rtl/a3000_spi_flash_bridge_spi_slave_sync.sv
// rtl/a3000_spi_flash_bridge_spi_slave_sync.sv - SPI input synchronisers and edge pulses
//
// Purpose: brings the asynchronous SCK/SS/MOSI into the clk domain and produces
//          single-clock pulses for SCK rise/fall and SS rise/fall.
// Ports:   clk, rst (sync active-high); sck, ss_n, mosi (async in);
//          sck_rise, sck_fall, ss_rise, ss_fall (pulses); ss_n_s, mosi_s (synced levels).

module spi_slave_sync (
    input  logic clk,
    input  logic rst,
    input  logic sck,
    input  logic ss_n,
    input  logic mosi,
    output logic sck_rise,
    output logic sck_fall,
    output logic ss_rise,
    output logic ss_fall,
    output logic ss_n_s,
    output logic mosi_s
);

    // [1:0] is the 2-flop synchroniser, [2] the history bit for edge detection.
    logic [2:0] sck_q;
    logic [2:0] ss_q;
    logic [1:0] mosi_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sck_q  <= '0;
            ss_q   <= '1;
            mosi_q <= '0;
        end else begin
            sck_q  <= {sck_q[1:0], sck};
            ss_q   <= {ss_q[1:0], ss_n};
            mosi_q <= {mosi_q[0], mosi};
        end
    end

    // MOSI goes through the same two stages as SCK, so at a detected rise it
    // still shows the value the master set up before that rise.
    assign sck_rise = sck_q[1] & ~sck_q[2];
    assign sck_fall = ~sck_q[1] & sck_q[2];
    assign ss_rise  = ss_q[1] & ~ss_q[2];
    assign ss_fall  = ~ss_q[1] & ss_q[2];
    assign ss_n_s   = ss_q[1];
    assign mosi_s   = mosi_q[1];

endmodule

// File: rtl/a3000_spi_flash_bridge.sv
// rtl/a3000_spi_flash_bridge.sv - SPI slave to parallel flash bridge for the A3000 ROM emulator
//
// Purpose: decodes MCU SPI frames (acc, rnw, addr, payload), arbitrates flash
//          ownership against the ARM ROM bus and runs one flash read/write cycle per
//          frame or burst chunk with a STROBE_CYC-clock nOE/nWE pulse.
// Ports:   cpld_clock_osc, cpld_reset (sync active-high);
//          cpld_SCK/cpld_SS/cpld_MOSI in, cpld_MISO out (SPI mode 0);
//          flash (interface, master): flash_A, flash_D_in/out, flash_D_oe, nCE/nOE/nWE;
//          allowing_arm_access, busy, frame_error status outputs.

module a3000_spi_flash_bridge
    import a3000_bridge_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int GAP_BITS   = DEF_GAP_BITS,
    parameter int STROBE_CYC = DEF_STROBE_CYC
) (
    input  logic                         cpld_clock_osc,
    input  logic                         cpld_reset,
    input  logic                         cpld_SCK,
    input  logic                         cpld_SS,
    input  logic                         cpld_MOSI,
    output logic                         cpld_MISO,
    a3000_spi_flash_bridge_if.master     flash,
    output logic                         allowing_arm_access,
    output logic                         busy,
    output logic                         frame_error
);

    localparam int HDR_LEN   = hdr_len(ADDR_W);
    localparam int FRAME_LEN = frame_len(ADDR_W, DATA_W, GAP_BITS);
    localparam int CNT_W     = cnt_width(FRAME_LEN);
    localparam int SCNT_W    = $clog2(STROBE_CYC + 1);

    localparam logic [CNT_W-1:0] P_HDR_LAST = CNT_W'(HDR_LEN - 1);
    localparam logic [CNT_W-1:0] P_HDR      = CNT_W'(HDR_LEN);
    localparam logic [CNT_W-1:0] P_WR_LAST  = CNT_W'(HDR_LEN + DATA_W - 1);
    localparam logic [CNT_W-1:0] P_RD_DATA  = CNT_W'(HDR_LEN + GAP_BITS);
    localparam logic [CNT_W-1:0] P_LAST     = CNT_W'(FRAME_LEN - 1);
    localparam logic [SCNT_W-1:0] S_LAST    = SCNT_W'(STROBE_CYC - 1);

    logic sck_rise, sck_fall, ss_rise, ss_fall, ss_n_s, mosi_s;

    spi_slave_sync u_sync (
        .clk      (cpld_clock_osc),
        .rst      (cpld_reset),
        .sck      (cpld_SCK),
        .ss_n     (cpld_SS),
        .mosi     (cpld_MOSI),
        .sck_rise (sck_rise),
        .sck_fall (sck_fall),
        .ss_rise  (ss_rise),
        .ss_fall  (ss_fall),
        .ss_n_s   (ss_n_s),
        .mosi_s   (mosi_s)
    );

    // Frame decoder state
    logic [CNT_W-1:0]  pos;       // bit index within the full-frame layout
    logic              acc_q;
    logic              rnw_q;
    logic              burst_q;   // past the first frame; pos restarts at P_HDR
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-2:0] din_sr;    // MSB not needed: the last bit comes straight from MOSI
    logic [DATA_W-1:0] out_sr;
    logic              miso_q;
    logic              allow_q;
    logic              ferr_q;
    logic              start_rd;
    logic              start_wr;
    logic [ADDR_W-1:0] cyc_addr;
    logic [DATA_W-1:0] cyc_data;

    // Flash FSM state
    flash_state_t      state;
    logic [SCNT_W-1:0] scnt;
    logic              cyc_rnw;
    logic              nce_q, noe_q, nwe_q, doe_q;
    logic [DATA_W-1:0] rd_data;
    logic              rd_load;

    always_ff @(posedge cpld_clock_osc) begin
        if (cpld_reset) begin
            pos      <= '0;
            acc_q    <= 1'b0;
            rnw_q    <= 1'b0;
            burst_q  <= 1'b0;
            addr_q   <= '0;
            din_sr   <= '0;
            out_sr   <= '0;
            miso_q   <= 1'b0;
            allow_q  <= 1'b1;
            ferr_q   <= 1'b0;
            start_rd <= 1'b0;
            start_wr <= 1'b0;
            cyc_addr <= '0;
            cyc_data <= '0;
        end else begin
            start_rd <= 1'b0;
            start_wr <= 1'b0;
            if (rd_load) out_sr <= rd_data;

            if (ss_fall) begin
                pos     <= '0;
                burst_q <= 1'b0;
                ferr_q  <= 1'b0;
                miso_q  <= 1'b0;
            end else if (ss_rise) begin
                // A clean end is either before any bit or exactly on a chunk boundary.
                if (pos != '0 && !(burst_q && pos == P_HDR)) ferr_q <= 1'b1;
                pos     <= '0;
                burst_q <= 1'b0;
                miso_q  <= 1'b0;
            end else if (!ss_n_s) begin
                if (sck_rise) begin
                    if (pos == '0)              acc_q  <= mosi_s;
                    else if (pos == CNT_W'(1))  rnw_q  <= mosi_s;
                    else if (pos < P_HDR)       addr_q <= {addr_q[ADDR_W-2:0], mosi_s};
                    else                        din_sr <= {din_sr[DATA_W-3:0], mosi_s};

                    if (pos == P_HDR_LAST) begin
                        allow_q <= acc_q;
                        if (!acc_q && rnw_q) begin
                            start_rd <= 1'b1;
                            cyc_addr <= {addr_q[ADDR_W-2:0], mosi_s};
                        end
                    end
                    if (!acc_q && !rnw_q && pos == P_WR_LAST) begin
                        start_wr <= 1'b1;
                        cyc_addr <= addr_q;
                        cyc_data <= {din_sr, mosi_s};
                    end
                    // Burst reads launch on the first bit of the chunk, so a frame that
                    // ends exactly at a chunk boundary never starts a spurious read.
                    if (!acc_q && rnw_q && burst_q && pos == P_HDR) begin
                        start_rd <= 1'b1;
                        cyc_addr <= addr_q;
                    end

                    if (pos == P_LAST) begin
                        pos     <= P_HDR;
                        burst_q <= 1'b1;
                        addr_q  <= addr_q + ADDR_W'(1);
                    end else begin
                        pos <= pos + CNT_W'(1);
                    end
                end

                if (sck_fall) begin
                    if (!acc_q && rnw_q && pos >= P_RD_DATA) begin
                        miso_q <= out_sr[DATA_W-1];
                        out_sr <= {out_sr[DATA_W-2:0], 1'b0};
                    end else begin
                        miso_q <= 1'b0;
                    end
                end
            end
        end
    end

    // Flash cycle sequencer; runs independently of further SCK activity.
    always_ff @(posedge cpld_clock_osc) begin
        if (cpld_reset) begin
            state   <= ST_IDLE;
            scnt    <= '0;
            cyc_rnw <= 1'b0;
            nce_q   <= 1'b1;
            noe_q   <= 1'b1;
            nwe_q   <= 1'b1;
            doe_q   <= 1'b0;
            rd_data <= '0;
            rd_load <= 1'b0;
        end else begin
            rd_load <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_rd || start_wr) begin
                        state   <= ST_SETUP;
                        nce_q   <= 1'b0;
                        cyc_rnw <= start_rd;
                        doe_q   <= start_wr;
                    end
                end
                ST_SETUP: begin
                    state <= ST_STROBE;
                    scnt  <= '0;
                    noe_q <= ~cyc_rnw;
                    nwe_q <= cyc_rnw;
                end
                ST_STROBE: begin
                    if (scnt == S_LAST) begin
                        state <= ST_HOLD;
                        noe_q <= 1'b1;
                        nwe_q <= 1'b1;
                        if (cyc_rnw) rd_data <= flash.flash_D_in;
                    end else begin
                        scnt <= scnt + SCNT_W'(1);
                    end
                end
                ST_HOLD: begin
                    state   <= ST_IDLE;
                    nce_q   <= 1'b1;
                    doe_q   <= 1'b0;
                    rd_load <= cyc_rnw;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // While the ARM bus owns the flash the bridge strobes and data drivers stay inert.
    assign flash.flash_A     = cyc_addr;
    assign flash.flash_D_out = cyc_data;
    assign flash.flash_D_oe  = doe_q & ~allow_q;
    assign flash.flash_nCE   = nce_q | allow_q;
    assign flash.flash_nOE   = noe_q | allow_q;
    assign flash.flash_nWE   = nwe_q | allow_q;

    assign cpld_MISO           = miso_q;
    assign allowing_arm_access = allow_q;
    assign busy                = (state != ST_IDLE);
    assign frame_error         = ferr_q;

endmodule
